regbus_arbiter: RTL and testbench
=================================

# regbus_arbiter

Round-robin arbiter that shares one 16-bit register's write port among four requesters. It sits in front of a `register_16bit` instance and drives that register's `load` and `in` from the winning requester. Each write is acknowledged with a one-cycle grant pulse. Grant, load and data are all registered, so the register captures the winning data exactly one cycle after the request is sampled.

## Interface
Parameters: none. Width is fixed at 16 bits and requester count at 4.

- clock  input  1  CPU clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req  input  4  req[i] high = requester i wants to write; level-sensitive
- data0  input  16  write data, requester 0
- data1  input  16  write data, requester 1
- data2  input  16  write data, requester 2
- data3  input  16  write data, requester 3
- stall  input  1  high = issue no grant this cycle
- grant  output  4  one-hot, one-cycle pulse; grant[i] = requester i won
- load_out  output  1  drives the register's `load`; equals the OR of `grant`
- data_out  output  16  drives the register's `in`; the winner's data
- last_id  output  2  index of the most recent winner (round-robin pointer)

## Operation
- Reset values:
  - grant = 4'b0000
  - load_out = 0
  - data_out = 16'h0000
  - last_id = 2'd3, so requester 0 has first priority after reset
- Arbitration runs every rising edge, except under reset or when stall=1.
- Eligibility:
  - eligible[i] = req[i] AND NOT grant[i], using the grant value currently being driven.
  - The requester granted in the current cycle cannot win at the next edge. This gives it one cycle to see its grant and drop req or change data.
- Search order (round-robin): last_id+1, last_id+2, last_id+3, last_id+4, all mod 4. The first eligible index wins.
- On a win by index w, the edge registers:
  - grant <= one-hot(w)
  - load_out <= 1
  - data_out <= data_w (sampled at that same edge)
  - last_id <= w
- With no eligible requester, or stall=1:
  - grant <= 0 and load_out <= 0
  - data_out holds its previous value
  - last_id is unchanged
- States:
  - IDLE: grant=0.
  - GRANT: grant is one-hot for exactly one cycle.
  - GRANT→GRANT is legal when a different requester is eligible.
- Simultaneous events:
  - All four requesting: each index is served in rotation order, one per cycle.
  - A lone continuous requester is served every other cycle because of the self-mask.
  - Reset has priority over stall, and reset mid-grant clears grant and load_out at that edge.
- Fairness: with round-robin, a requester holding req high waits at most 4 cycles for a grant.

## Timing
- Latency: req[i] high and sampled at edge E → grant[i] and load_out high during cycle E..E+1 → the register's `out` equals the sampled data_i after edge E+1.
- grant is exactly one cycle wide per win.
- A requester must hold req and its data stable until it observes its grant high. The arbiter ignores data after the sampling edge.
- stall is sampled at the same edge as req and blocks only that edge's arbitration.
- There are no combinational paths from inputs to outputs.

## Configuration
- `REGBUS_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; search order is always 0, 1, 2, 3.
  - last_id is still updated with the winner, but it does not affect arbitration.
  - The self-mask still applies.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then req=4'b0001 and data0=16'hA5A5 for one edge → grant=4'b0001 and load_out=1 for one cycle; the downstream register reads 16'hA5A5 one edge later; last_id=0.
- req=4'b1111 held, with data0..data3 = 16'h1111/2222/3333/4444 → grants in order 0, 1, 2, 3, 0 on consecutive cycles; register sequence 1111, 2222, 3333, 4444, 1111.
- Only req[2] held high for 6 cycles → grant[2] pulses on cycles 1, 3 and 5 and is 0 on cycles 2, 4 and 6.
- req=4'b0110 with stall=1 for 3 cycles, then stall=0 → no grant and data_out unchanged during the stall; grant=4'b0010 on the first unstalled edge.
- Assert reset in the cycle grant=4'b0100 is high → after the edge, grant=0, load_out=0, data_out=16'h0000, last_id=3.
- With `REGBUS_ARB_FIXED_PRIO_EN` defined and req=4'b1001 held → grants alternate 0, 3, 0, 3; requester 3 wins only in the cycles where the self-mask blocks requester 0.

Source files
------------

// File: rtl/regbus_arbiter_if.sv
// Register write-port bus between four requesters and the round-robin
// arbiter that feeds a register_16bit instance.
//
// Handshake: a requester raises req[i] with data<i> and holds both stable
// until it sees grant[i] high. grant is a one-cycle pulse. The requester
// that is granted is masked for the following edge. stall blocks only the
// arbitration of the edge at which it is sampled.
interface regbus_arbiter_if;
   logic [3:0]  req;
   logic [15:0] data0;
   logic [15:0] data1;
   logic [15:0] data2;
   logic [15:0] data3;
   logic        stall;
   logic [3:0]  grant;
   logic        load_out;
   logic [15:0] data_out;
   logic [1:0]  last_id;
   logic        state_dbg;   // arbiter FSM state: 0 = IDLE, 1 = GRANT

   modport master (
      output req, data0, data1, data2, data3, stall,
      input  grant, load_out, data_out, last_id, state_dbg
   );

   modport slave (
      input  req, data0, data1, data2, data3, stall,
      output grant, load_out, data_out, last_id, state_dbg
   );
endinterface

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: shares one 16-bit register write port among four
// requesters. grant, load and data are registered, so the register captures
// the winning data one edge after the request is sampled.
// Optional macro REGBUS_ARB_FIXED_PRIO_EN selects fixed priority (0..3)
// instead of round-robin. last_id is still tracked in that mode.
module regbus_arbiter (
   input  logic               clock,
   input  logic               reset,
   regbus_arbiter_if.slave    bus
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic        load_q, load_d;
   logic [15:0] data_q, data_d;
   logic [1:0]  last_q, last_d;

   logic [3:0]  eligible;
   logic        found;
   logic [1:0]  win;
   logic [1:0]  cand;
   logic [15:0] win_data;

   // The requester being granted right now is masked for one edge.
   assign eligible = bus.req & ~grant_q;

   // Winner search: first eligible index in priority order.
   always_comb begin
      found = 1'b0;
      win   = last_q;
      cand  = 2'd0;
      for (int k = 1; k <= 4; k++) begin
`ifdef REGBUS_ARB_FIXED_PRIO_EN
         cand = 2'(k - 1);
`else
         cand = last_q + 2'(k);
`endif
         if (!found && eligible[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Select the winner's write data.
   always_comb begin
      win_data = bus.data0;
      case (win)
         2'd0: win_data = bus.data0;
         2'd1: win_data = bus.data1;
         2'd2: win_data = bus.data2;
         2'd3: win_data = bus.data3;
         default: win_data = bus.data0;
      endcase
   end

   // Next-state and registered outputs: grant on a win, otherwise idle.
   always_comb begin
      state_d = IDLE;
      grant_d = 4'b0000;
      load_d  = 1'b0;
      data_d  = data_q;
      last_d  = last_q;
      if (!bus.stall && found) begin
         state_d = GRANT;
         grant_d = 4'b0001 << win;
         load_d  = 1'b1;
         data_d  = win_data;
         last_d  = win;
      end
   end

   // State register. Reset leaves the pointer at 3 so requester 0 goes first.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 4'b0000;
         load_q  <= 1'b0;
         data_q  <= 16'h0000;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         load_q  <= load_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.load_out  = load_q;
   assign bus.data_out  = data_q;
   assign bus.last_id   = last_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Testbench for regbus_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model, with a downstream register model.
module tb_regbus_arbiter;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   regbus_arbiter_if bus();

   regbus_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Clock generation
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Downstream register_16bit stand-in
   logic [15:0] reg_out;
   always_ff @(posedge clock) begin
      if (reset) reg_out <= 16'h0000;
      else if (bus.load_out) reg_out <= bus.data_out;
   end

   // Behavioural model state
   logic [3:0]  m_grant;
   logic        m_load;
   logic [15:0] m_data;
   int          m_last;
   logic [15:0] m_reg;

   function automatic logic [15:0] req_data(int i);
      case (i)
         0: return bus.data0;
         1: return bus.data1;
         2: return bus.data2;
         default: return bus.data3;
      endcase
   endfunction

   // Advance one clock: update model from current inputs, then step the DUT.
   task automatic tick();
      int win;
      int idx;
      if (reset) begin
         m_grant = 4'b0000;
         m_load  = 1'b0;
         m_data  = 16'h0000;
         m_last  = 3;
         m_reg   = 16'h0000;
      end else begin
         if (m_load) m_reg = m_data;
         win = -1;
         if (!bus.stall) begin
            for (int k = 0; k < 4; k++) begin
`ifdef REGBUS_ARB_FIXED_PRIO_EN
               idx = k;
`else
               idx = (m_last + 1 + k) % 4;
`endif
               if (win < 0 && bus.req[idx] && !m_grant[idx]) win = idx;
            end
         end
         if (win >= 0) begin
            m_grant = 4'(1 << win);
            m_load  = 1'b1;
            m_data  = req_data(win);
            m_last  = win;
         end else begin
            m_grant = 4'b0000;
            m_load  = 1'b0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      bus.req   = 4'b0000;
      bus.stall = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=%b", bus.grant, 4'b0000); end
      total++; if (bus.load_out !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", bus.load_out); end
      total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", bus.data_out); end
      total++; if (bus.last_id !== 2'd3) begin bad++; $display("FAIL reset_last got=%0d exp=3", bus.last_id); end
   endtask

   task automatic test_single();
      do_reset();
      bus.req   = 4'b0001;
      bus.data0 = 16'hA5A5;
      tick();
      bus.req = 4'b0000;
      total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.grant); end
      total++; if (bus.load_out !== 1'b1) begin bad++; $display("FAIL single_load got=%b exp=1", bus.load_out); end
      total++; if (bus.last_id !== 2'd0) begin bad++; $display("FAIL single_last got=%0d exp=0", bus.last_id); end
      tick();
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL single_pulse got=%b exp=0000", bus.grant); end
      total++; if (reg_out !== 16'hA5A5) begin bad++; $display("FAIL single_reg got=%h exp=a5a5", reg_out); end
   endtask

   task automatic test_all_req();
      logic [15:0] vals [4];
      int          order [6];
      vals  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      order = '{0, 1, 2, 3, 0, 1};
      do_reset();
      bus.data0 = vals[0];
      bus.data1 = vals[1];
      bus.data2 = vals[2];
      bus.data3 = vals[3];
      bus.req   = 4'b1111;
      for (int j = 0; j < 6; j++) begin
         tick();
         total++;
         if (bus.grant !== 4'(1 << order[j])) begin
            bad++; $display("FAIL rr_grant step=%0d got=%b exp=%b", j, bus.grant, 4'(1 << order[j]));
         end
         if (j >= 1) begin
            total++;
            if (reg_out !== vals[order[j-1]]) begin
               bad++; $display("FAIL rr_reg step=%0d got=%h exp=%h", j, reg_out, vals[order[j-1]]);
            end
         end
      end
      bus.req = 4'b0000;
   endtask

   task automatic test_lone();
      do_reset();
      bus.req = 4'b0100;
      for (int j = 0; j < 6; j++) begin
         tick();
         total++;
         if (bus.grant[2] !== ((j % 2) == 0)) begin
            bad++; $display("FAIL lone_grant cycle=%0d got=%b exp=%b", j + 1, bus.grant[2], (j % 2) == 0);
         end
      end
      bus.req = 4'b0000;
   endtask

   task automatic test_stall();
      do_reset();
      bus.req   = 4'b0110;
      bus.stall = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL stall_grant cycle=%0d got=%b exp=0000", j, bus.grant); end
         total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL stall_data cycle=%0d got=%h exp=0000", j, bus.data_out); end
      end
      bus.stall = 1'b0;
      tick();
      total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL stall_release got=%b exp=0010", bus.grant); end
      bus.req = 4'b0000;
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      bus.req   = 4'b0100;
      bus.data2 = 16'hBEEF;
      tick();
      total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL midrst_pre got=%b exp=0100", bus.grant); end
      reset     = 1'b1;
      bus.stall = 1'b1;
      tick();
      reset     = 1'b0;
      bus.stall = 1'b0;
      bus.req   = 4'b0000;
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL midrst_grant got=%b exp=0000", bus.grant); end
      total++; if (bus.load_out !== 1'b0) begin bad++; $display("FAIL midrst_load got=%b exp=0", bus.load_out); end
      total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL midrst_data got=%h exp=0000", bus.data_out); end
      total++; if (bus.last_id !== 2'd3) begin bad++; $display("FAIL midrst_last got=%0d exp=3", bus.last_id); end
   endtask

   task automatic test_pair();
      int exp_w [4];
      exp_w = '{0, 3, 0, 3};
      do_reset();
      bus.req = 4'b1001;
      for (int j = 0; j < 4; j++) begin
         tick();
         total++;
         if (bus.grant !== 4'(1 << exp_w[j])) begin
            bad++; $display("FAIL pair_grant step=%0d got=%b exp=%b", j, bus.grant, 4'(1 << exp_w[j]));
         end
      end
      bus.req = 4'b0000;
   endtask

   task automatic test_random();
      do_reset();
      for (int j = 0; j < 400; j++) begin
         bus.req   = 4'($urandom_range(0, 15));
         bus.data0 = 16'($urandom);
         bus.data1 = 16'($urandom);
         bus.data2 = 16'($urandom);
         bus.data3 = 16'($urandom);
         bus.stall = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 59) == 0);
         tick();
         total++; if (bus.grant !== m_grant) begin bad++; $display("FAIL rnd_grant i=%0d got=%b exp=%b", j, bus.grant, m_grant); end
         total++; if (bus.load_out !== m_load) begin bad++; $display("FAIL rnd_load i=%0d got=%b exp=%b", j, bus.load_out, m_load); end
         total++; if (bus.data_out !== m_data) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", j, bus.data_out, m_data); end
         total++; if (bus.last_id !== 2'(m_last)) begin bad++; $display("FAIL rnd_last i=%0d got=%0d exp=%0d", j, bus.last_id, m_last); end
         total++; if (reg_out !== m_reg) begin bad++; $display("FAIL rnd_reg i=%0d got=%h exp=%h", j, reg_out, m_reg); end
      end
      reset   = 1'b0;
      bus.req = 4'b0000;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      bus.req   = 4'b0000;
      bus.stall = 1'b0;
      bus.data0 = 16'h0000;
      bus.data1 = 16'h0000;
      bus.data2 = 16'h0000;
      bus.data3 = 16'h0000;
      m_grant   = 4'b0000;
      m_load    = 1'b0;
      m_data    = 16'h0000;
      m_last    = 3;
      m_reg     = 16'h0000;
      @(negedge clock);
      test_reset();
      test_single();
      test_all_req();
      test_lone();
      test_stall();
      test_reset_mid_grant();
      test_pair();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
